// File: rtl/uproc_pkg.sv
// Shared definitions for the uProcessor: instruction field widths, opcode
// encodings, the NOP instruction word and the program-memory state type.
package uproc_pkg;

  localparam int OPC_W_DEF = 5;
  localparam int OPD_W_DEF = 8;
  localparam int INS_W_DEF = OPC_W_DEF + OPD_W_DEF;

  localparam logic [OPC_W_DEF-1:0] OPCODE_NOP    = 5'h00;
  localparam logic [OPC_W_DEF-1:0] OPCODE_LD_IMD = 5'h01;
  localparam logic [OPC_W_DEF-1:0] OPCODE_LD_MEM = 5'h02;
  localparam logic [OPC_W_DEF-1:0] OPCODE_ST_MEM = 5'h03;
  localparam logic [OPC_W_DEF-1:0] OPCODE_ADD_R  = 5'h04;
  localparam logic [OPC_W_DEF-1:0] OPCODE_SUB_R  = 5'h05;
  localparam logic [OPC_W_DEF-1:0] OPCODE_AND_R  = 5'h06;
  localparam logic [OPC_W_DEF-1:0] OPCODE_OR_R   = 5'h07;
  localparam logic [OPC_W_DEF-1:0] OPCODE_XOR_R  = 5'h08;
  localparam logic [OPC_W_DEF-1:0] OPCODE_JMP    = 5'h09;
  localparam logic [OPC_W_DEF-1:0] OPCODE_JZ     = 5'h0A;
  localparam logic [OPC_W_DEF-1:0] OPCODE_HALT   = 5'h1F;

  localparam logic [OPD_W_DEF-1:0] REG_R0 = 8'd0;
  localparam logic [OPD_W_DEF-1:0] REG_R1 = 8'd1;
  localparam logic [OPD_W_DEF-1:0] REG_R2 = 8'd2;
  localparam logic [OPD_W_DEF-1:0] REG_R3 = 8'd3;

  // Opcode occupies the upper bits, operand the lower bits.
  localparam logic [INS_W_DEF-1:0] NOP_WORD = {OPCODE_NOP, {OPD_W_DEF{1'b0}}};

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    LOAD  = 2'd2
  } pm_state_t;

  // Builds an instruction word at the default field widths.
  function automatic logic [INS_W_DEF-1:0] pack_ins(
    input logic [OPC_W_DEF-1:0] opc,
    input logic [OPD_W_DEF-1:0] opd
  );
    return {opc, opd};
  endfunction

endpackage

// File: rtl/prog_mem_array.sv
// Program storage: DEPTH x INS_W words with one synchronous write port and one
// synchronous read port whose output register holds until the next read.
module prog_mem_array #(
  parameter int ADDR_W = 6,
  parameter int INS_W  = 13,
  parameter logic [INS_W-1:0] RST_WORD = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [INS_W-1:0]  i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [INS_W-1:0]  o_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [INS_W-1:0] r_mem [DEPTH];
  logic [INS_W-1:0] r_rdata;

  // Storage has no reset; the controller sweeps NOPs through it after reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read register only updates on a read, so the fetched word is held.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= RST_WORD;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/prog_mem_rw.sv
// Writable program memory for the fetch stage. After reset the array is swept
// to NOP, then the core fetches from it; a streaming loader can rewrite it
// starting at address 0 while fetching is paused.
module prog_mem_rw
  import uproc_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int OPC_W  = OPC_W_DEF,
  parameter int OPD_W  = OPD_W_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_fetch_en,
  input  logic [ADDR_W-1:0]      i_fetch_addr,
  output logic                   o_fetch_ready,
  output logic [OPC_W+OPD_W-1:0] o_ins_out,
  output logic                   o_ins_valid,
  input  logic                   i_load_start,
  input  logic                   i_load_valid,
  input  logic [OPC_W+OPD_W-1:0] i_load_data,
  input  logic                   i_load_last,
  output logic                   o_load_ready,
  output logic                   o_load_done,
  output logic                   o_load_err,
  output logic                   o_busy
);

  localparam int INS_W = OPC_W + OPD_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [INS_W-1:0]  NOP_INS   = {OPC_W'(OPCODE_NOP), {OPD_W{1'b0}}};

  pm_state_t         r_state;
  pm_state_t         w_state_next;
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] w_wptr_next;

  logic              w_we;
  logic [INS_W-1:0]  w_wdata;
  logic              w_fetch_acc;
  logic              w_load_acc;
  logic              w_load_fin;
  logic              w_load_ovf;
  logic [INS_W-1:0]  w_rdata;

  logic              r_fetch_ready;
  logic              r_load_ready;
  logic              r_busy;
  logic              r_ins_valid;
  logic              r_load_done;
  logic              r_load_err;

  // The ready flags mirror the current state, so they double as handshake
  // qualifiers without re-decoding the state here.
  assign w_fetch_acc = i_fetch_en && r_fetch_ready;
  assign w_load_acc  = i_load_valid && r_load_ready;

  // Next-state, write-pointer and write-port control.
  always_comb begin
    w_state_next = r_state;
    w_wptr_next  = r_wptr;
    w_we         = 1'b0;
    w_wdata      = NOP_INS;
    w_load_fin   = 1'b0;
    w_load_ovf   = 1'b0;
    case (r_state)
      CLEAR: begin
        w_we        = 1'b1;
        w_wdata     = NOP_INS;
        w_wptr_next = r_wptr + 1'b1;
        if (r_wptr == LAST_ADDR) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (i_load_start) begin
          w_state_next = LOAD;
          w_wptr_next  = '0;
        end
      end
      LOAD: begin
        if (w_load_acc) begin
          w_we        = 1'b1;
          w_wdata     = i_load_data;
          w_wptr_next = r_wptr + 1'b1;
          if (i_load_last) begin
            w_state_next = RUN;
            w_load_fin   = 1'b1;
          end else if (r_wptr == LAST_ADDR) begin
            w_state_next = RUN;
            w_load_ovf   = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = CLEAR;
        w_wptr_next  = '0;
      end
    endcase
  end

  // State and write pointer; reset restarts the NOP sweep from address 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= CLEAR;
      r_wptr  <= '0;
    end else begin
      r_state <= w_state_next;
      r_wptr  <= w_wptr_next;
    end
  end

  // Registered status flags and one-cycle pulses, decoded from the next state
  // so they line up with the state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fetch_ready <= 1'b0;
      r_load_ready  <= 1'b0;
      r_busy        <= 1'b1;
      r_ins_valid   <= 1'b0;
      r_load_done   <= 1'b0;
      r_load_err    <= 1'b0;
    end else begin
      r_fetch_ready <= (w_state_next == RUN);
      r_load_ready  <= (w_state_next == LOAD);
      r_busy        <= (w_state_next == CLEAR) || (w_state_next == LOAD);
      r_ins_valid   <= w_fetch_acc;
      r_load_done   <= w_load_fin;
      r_load_err    <= w_load_ovf;
    end
  end

  prog_mem_array #(
    .ADDR_W   (ADDR_W),
    .INS_W    (INS_W),
    .RST_WORD (NOP_INS)
  ) u_array (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (w_we),
    .i_waddr (r_wptr),
    .i_wdata (w_wdata),
    .i_re    (w_fetch_acc),
    .i_raddr (i_fetch_addr),
    .o_rdata (w_rdata)
  );

  assign o_ins_out     = w_rdata;
  assign o_fetch_ready = r_fetch_ready;
  assign o_ins_valid   = r_ins_valid;
  assign o_load_ready  = r_load_ready;
  assign o_load_done   = r_load_done;
  assign o_load_err    = r_load_err;
  assign o_busy        = r_busy;

endmodule

// File: tb/tb_prog_mem_rw.sv
// Directed testbench for prog_mem_rw at default widths (64 x 13-bit words).
module tb_prog_mem_rw;

  logic        i_clk;
  logic        i_rst;
  logic        i_fetch_en;
  logic [5:0]  i_fetch_addr;
  logic        o_fetch_ready;
  logic [12:0] o_ins_out;
  logic        o_ins_valid;
  logic        i_load_start;
  logic        i_load_valid;
  logic [12:0] i_load_data;
  logic        i_load_last;
  logic        o_load_ready;
  logic        o_load_done;
  logic        o_load_err;
  logic        o_busy;

  int checks;
  int errors;

  localparam logic [12:0] NOP   = 13'h0000;
  localparam logic [12:0] W_ADD = 13'h0401;
  localparam logic [12:0] W_SUB = 13'h0501;
  localparam logic [12:0] W_LDI = 13'h0105;

  prog_mem_rw dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_fetch_en    (i_fetch_en),
    .i_fetch_addr  (i_fetch_addr),
    .o_fetch_ready (o_fetch_ready),
    .o_ins_out     (o_ins_out),
    .o_ins_valid   (o_ins_valid),
    .i_load_start  (i_load_start),
    .i_load_valid  (i_load_valid),
    .i_load_data   (i_load_data),
    .i_load_last   (i_load_last),
    .o_load_ready  (o_load_ready),
    .o_load_done   (o_load_done),
    .o_load_err    (o_load_err),
    .o_busy        (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Drives one cycle of inputs, then steps past the next rising edge so the
  // caller sees the registered results of that edge.
  task automatic applyStimulus(input logic fetchEn, input logic [5:0] fetchAddr,
                               input logic loadStart, input logic loadValid,
                               input logic [12:0] loadData, input logic loadLast);
    i_fetch_en   = fetchEn;
    i_fetch_addr = fetchAddr;
    i_load_start = loadStart;
    i_load_valid = loadValid;
    i_load_data  = loadData;
    i_load_last  = loadLast;
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One fetch request; the word and its valid pulse appear the following cycle.
  task automatic fetchExpect(input string tag, input logic [5:0] addr,
                             input logic [12:0] expected);
    applyStimulus(1'b1, addr, 1'b0, 1'b0, 13'h0, 1'b0);
    checkOutput({tag, "_valid"}, {31'd0, o_ins_valid}, 32'd1);
    checkOutput({tag, "_data"}, {19'd0, o_ins_out}, {19'd0, expected});
  endtask

  task automatic idle();
    applyStimulus(1'b0, 6'd0, 1'b0, 1'b0, 13'h0, 1'b0);
  endtask

  logic doneSeen;
  logic busyLow;

  initial begin
    checks = 0;
    errors = 0;
    i_rst  = 1'b1;
    idle();
    idle();

    // Reset values
    checkOutput("rst_busy", {31'd0, o_busy}, 32'd1);
    checkOutput("rst_fetch_ready", {31'd0, o_fetch_ready}, 32'd0);
    checkOutput("rst_load_ready", {31'd0, o_load_ready}, 32'd0);
    checkOutput("rst_ins_valid", {31'd0, o_ins_valid}, 32'd0);
    checkOutput("rst_load_done", {31'd0, o_load_done}, 32'd0);
    checkOutput("rst_load_err", {31'd0, o_load_err}, 32'd0);
    checkOutput("rst_ins_out", {19'd0, o_ins_out}, {19'd0, NOP});

    // CLEAR: 64 cycles; fetch and load_start requests are ignored meanwhile
    i_rst = 1'b0;
    for (int i = 0; i < 63; i++) applyStimulus(1'b1, 6'd5, 1'b1, 1'b0, 13'h0, 1'b0);
    checkOutput("clr63_busy", {31'd0, o_busy}, 32'd1);
    checkOutput("clr63_fetch_ready", {31'd0, o_fetch_ready}, 32'd0);
    checkOutput("clr63_ins_valid", {31'd0, o_ins_valid}, 32'd0);
    checkOutput("clr63_load_ready", {31'd0, o_load_ready}, 32'd0);
    idle();
    checkOutput("clr64_busy", {31'd0, o_busy}, 32'd0);
    checkOutput("clr64_fetch_ready", {31'd0, o_fetch_ready}, 32'd1);
    checkOutput("clr64_load_ready", {31'd0, o_load_ready}, 32'd0);

    // Back-to-back fetches of the cleared array
    fetchExpect("clr_f0", 6'd0, NOP);
    fetchExpect("clr_f17", 6'd17, NOP);
    fetchExpect("clr_f63", 6'd63, NOP);
    idle();
    checkOutput("idle_ins_valid", {31'd0, o_ins_valid}, 32'd0);

    // Three-word load
    applyStimulus(1'b0, 6'd0, 1'b1, 1'b0, 13'h0, 1'b0);
    checkOutput("ld3_load_ready", {31'd0, o_load_ready}, 32'd1);
    checkOutput("ld3_fetch_ready", {31'd0, o_fetch_ready}, 32'd0);
    checkOutput("ld3_busy", {31'd0, o_busy}, 32'd1);
    applyStimulus(1'b0, 6'd0, 1'b0, 1'b1, W_ADD, 1'b0);
    applyStimulus(1'b0, 6'd0, 1'b0, 1'b1, W_SUB, 1'b0);
    checkOutput("ld3_mid_done", {31'd0, o_load_done}, 32'd0);
    applyStimulus(1'b0, 6'd0, 1'b0, 1'b1, W_LDI, 1'b1);
    checkOutput("ld3_done", {31'd0, o_load_done}, 32'd1);
    checkOutput("ld3_err", {31'd0, o_load_err}, 32'd0);
    checkOutput("ld3_end_fetch_ready", {31'd0, o_fetch_ready}, 32'd1);
    checkOutput("ld3_end_busy", {31'd0, o_busy}, 32'd0);
    idle();
    checkOutput("ld3_done_pulse", {31'd0, o_load_done}, 32'd0);
    fetchExpect("ld3_f0", 6'd0, W_ADD);
    fetchExpect("ld3_f1", 6'd1, W_SUB);
    fetchExpect("ld3_f2", 6'd2, W_LDI);
    fetchExpect("ld3_f3", 6'd3, NOP);

    // 64 words with no last: overflow error after word 64
    applyStimulus(1'b0, 6'd0, 1'b1, 1'b0, 13'h0, 1'b0);
    for (int i = 0; i < 63; i++) applyStimulus(1'b0, 6'd0, 1'b0, 1'b1, 13'(4096 + i), 1'b0);
    checkOutput("ovf63_load_ready", {31'd0, o_load_ready}, 32'd1);
    checkOutput("ovf63_err", {31'd0, o_load_err}, 32'd0);
    applyStimulus(1'b0, 6'd0, 1'b0, 1'b1, 13'h103F, 1'b0);
    checkOutput("ovf_err", {31'd0, o_load_err}, 32'd1);
    checkOutput("ovf_done", {31'd0, o_load_done}, 32'd0);
    checkOutput("ovf_fetch_ready", {31'd0, o_fetch_ready}, 32'd1);
    checkOutput("ovf_load_ready", {31'd0, o_load_ready}, 32'd0);
    idle();
    checkOutput("ovf_err_pulse", {31'd0, o_load_err}, 32'd0);
    fetchExpect("ovf_f63", 6'd63, 13'h103F);
    fetchExpect("ovf_f0", 6'd0, 13'h1000);

    // 64 words with last on word 64: done only
    applyStimulus(1'b0, 6'd0, 1'b1, 1'b0, 13'h0, 1'b0);
    for (int i = 0; i < 63; i++) applyStimulus(1'b0, 6'd0, 1'b0, 1'b1, 13'(4352 + i), 1'b0);
    applyStimulus(1'b0, 6'd0, 1'b0, 1'b1, 13'h113F, 1'b1);
    checkOutput("full_done", {31'd0, o_load_done}, 32'd1);
    checkOutput("full_err", {31'd0, o_load_err}, 32'd0);
    idle();
    fetchExpect("full_f63", 6'd63, 13'h113F);

    // Loader gap of two cycles mid-stream (load_start in LOAD is ignored)
    applyStimulus(1'b0, 6'd0, 1'b1, 1'b0, 13'h0, 1'b0);
    applyStimulus(1'b0, 6'd0, 1'b0, 1'b1, 13'h0A01, 1'b0);
    applyStimulus(1'b0, 6'd0, 1'b0, 1'b1, 13'h0A02, 1'b0);
    applyStimulus(1'b0, 6'd0, 1'b1, 1'b0, 13'h1FFF, 1'b1);
    applyStimulus(1'b0, 6'd0, 1'b0, 1'b0, 13'h1FFF, 1'b1);
    checkOutput("gap_load_ready", {31'd0, o_load_ready}, 32'd1);
    checkOutput("gap_done", {31'd0, o_load_done}, 32'd0);
    applyStimulus(1'b0, 6'd0, 1'b0, 1'b1, 13'h0A03, 1'b1);
    checkOutput("gap_end_done", {31'd0, o_load_done}, 32'd1);
    idle();
    fetchExpect("gap_f0", 6'd0, 13'h0A01);
    fetchExpect("gap_f1", 6'd1, 13'h0A02);
    fetchExpect("gap_f2", 6'd2, 13'h0A03);
    fetchExpect("gap_f3", 6'd3, 13'h1103);
    idle();

    // Fetch and load_start together: fetch completes with the old word
    applyStimulus(1'b1, 6'd1, 1'b1, 1'b0, 13'h0, 1'b0);
    checkOutput("same_valid", {31'd0, o_ins_valid}, 32'd1);
    checkOutput("same_data", {19'd0, o_ins_out}, 32'h0A02);
    checkOutput("same_fetch_ready", {31'd0, o_fetch_ready}, 32'd0);
    checkOutput("same_load_ready", {31'd0, o_load_ready}, 32'd1);
    applyStimulus(1'b1, 6'd2, 1'b0, 1'b1, 13'h0B01, 1'b1);
    checkOutput("same_ld_valid", {31'd0, o_ins_valid}, 32'd0);
    checkOutput("same_ld_hold", {19'd0, o_ins_out}, 32'h0A02);
    checkOutput("same_ld_done", {31'd0, o_load_done}, 32'd1);
    idle();
    fetchExpect("same_f0", 6'd0, 13'h0B01);
    fetchExpect("same_f1", 6'd1, 13'h0A02);

    // Reset mid-load: array swept back to NOP, no done pulse
    applyStimulus(1'b0, 6'd0, 1'b1, 1'b0, 13'h0, 1'b0);
    applyStimulus(1'b0, 6'd0, 1'b0, 1'b1, 13'h0C01, 1'b0);
    applyStimulus(1'b0, 6'd0, 1'b0, 1'b1, 13'h0C02, 1'b0);
    i_rst = 1'b1;
    applyStimulus(1'b0, 6'd0, 1'b0, 1'b1, 13'h0C03, 1'b0);
    checkOutput("mrst_busy", {31'd0, o_busy}, 32'd1);
    checkOutput("mrst_load_ready", {31'd0, o_load_ready}, 32'd0);
    checkOutput("mrst_ins_out", {19'd0, o_ins_out}, {19'd0, NOP});
    i_rst    = 1'b0;
    doneSeen = 1'b0;
    busyLow  = 1'b0;
    for (int i = 0; i < 63; i++) begin
      idle();
      doneSeen = doneSeen | o_load_done;
      busyLow  = busyLow | ~o_busy;
    end
    checkOutput("mrst_no_done", {31'd0, doneSeen}, 32'd0);
    checkOutput("mrst_busy_held", {31'd0, busyLow}, 32'd0);
    idle();
    checkOutput("mrst_busy_drop", {31'd0, o_busy}, 32'd0);
    fetchExpect("mrst_f0", 6'd0, NOP);
    fetchExpect("mrst_f1", 6'd1, NOP);
    fetchExpect("mrst_f2", 6'd2, NOP);
    fetchExpect("mrst_f63", 6'd63, NOP);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
